// File: rtl/d_bridge_pkg.sv
// rtl/d_bridge_pkg.sv - state encoding, byte-lane constants and defaults for d_mem_byte_bridge
package d_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Address LSB selecting each half of a big-endian word
  localparam logic BYTE_HI = 1'b0;
  localparam logic BYTE_LO = 1'b1;

  localparam logic [15:0] DEFAULT_BUS_ERR_DATA = 16'hFFFF;

endpackage

// File: rtl/d_bridge_timeout.sv
// rtl/d_bridge_timeout.sv - per-beat ext bus timeout counter; TIMEOUT=0 disables expiry
module d_bridge_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic a_rst,
  input  logic req,
  input  logic ack,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] LIMIT = CW'(LIM);
  localparam logic ENABLE = (TIMEOUT > 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      cnt <= '0;
    end else if (clear || !req || ack) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires on the stalled cycle whose increment would reach TIMEOUT
  assign expired = ENABLE & req & ~ack & (cnt == LIMIT);

endmodule

// File: rtl/d_mem_byte_bridge.sv
// rtl/d_mem_byte_bridge.sv - 16-bit core data port to 8-bit ext bus bridge; option D_BRIDGE_POSTED_WRITE_EN
module d_mem_byte_bridge
  import d_bridge_pkg::*;
#(
  parameter int          TIMEOUT      = 255,
  parameter logic [15:0] BUS_ERR_DATA = DEFAULT_BUS_ERR_DATA
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        d_mem_assert,
  input  logic        d_mem_cmd,
  input  logic        d_mem_be0,
  input  logic        d_mem_be1,
  input  logic [15:0] d_mem_addr,
  input  logic [15:0] d_mem_data_out,
  output logic [15:0] d_mem_data_in,
  output logic        d_mem_rdy,
  output logic        d_mem_err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack
);

  state_t      state, state_nxt;
  logic        word_q, posted_q;
  logic [7:0]  wdata_lo_q, rd_hi_q;
  logic [15:0] rd_result;
  logic        beat_done, expired, accept, is_word, posted_accept, finish;

  assign beat_done = ext_req & ext_ack;
  assign accept    = (state == IDLE) & d_mem_assert;
  assign is_word   = d_mem_be0 & d_mem_be1;
  assign finish    = ((state == BEAT1) & beat_done) | expired;

`ifdef D_BRIDGE_POSTED_WRITE_EN
  assign posted_accept = accept & d_mem_cmd;
`else
  assign posted_accept = 1'b0;
`endif

  d_bridge_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .a_rst   (a_rst),
    .req     (ext_req),
    .ack     (ext_ack),
    .clear   (accept | expired),
    .expired (expired)
  );

  always_comb begin
    if (expired) begin
      rd_result = word_q ? BUS_ERR_DATA : {8'h00, BUS_ERR_DATA[7:0]};
    end else begin
      rd_result = word_q ? {rd_hi_q, ext_rdata} : {8'h00, ext_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A posted drain returns straight to IDLE so the core never sees its completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = is_word ? BEAT0 : BEAT1;
      BEAT0:   if (expired) state_nxt = posted_q ? IDLE : DONE;
               else if (beat_done) state_nxt = BEAT1;
      BEAT1:   if (finish) state_nxt = posted_q ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      ext_req       <= 1'b0;
      ext_we        <= 1'b0;
      ext_addr      <= 16'h0000;
      ext_wdata     <= 8'h00;
      d_mem_rdy     <= 1'b0;
      d_mem_err     <= 1'b0;
      d_mem_data_in <= 16'h0000;
      word_q        <= 1'b0;
      posted_q      <= 1'b0;
      wdata_lo_q    <= 8'h00;
      rd_hi_q       <= 8'h00;
    end else begin
      d_mem_rdy <= 1'b0;
      d_mem_err <= 1'b0;
      if (accept) begin
        ext_req    <= 1'b1;
        ext_we     <= d_mem_cmd;
        ext_addr   <= is_word ? {d_mem_addr[15:1], BYTE_HI} : d_mem_addr;
        ext_wdata  <= is_word ? d_mem_data_out[15:8] : d_mem_data_out[7:0];
        wdata_lo_q <= d_mem_data_out[7:0];
        word_q     <= is_word;
        posted_q   <= posted_accept;
        d_mem_rdy  <= posted_accept;
      end else if (finish) begin
        ext_req  <= 1'b0;
        ext_we   <= 1'b0;
        posted_q <= 1'b0;
        if (!posted_q) begin
          d_mem_rdy <= 1'b1;
          d_mem_err <= expired;
          if (!ext_we) d_mem_data_in <= rd_result;
        end
      end else if ((state == BEAT0) && beat_done) begin
        rd_hi_q   <= ext_rdata;
        ext_addr  <= {ext_addr[15:1], BYTE_LO};
        ext_wdata <= wdata_lo_q;
      end
    end
  end

endmodule

// File: tb/tb_d_mem_byte_bridge.sv
// tb/tb_d_mem_byte_bridge.sv - scoreboard bench for d_mem_byte_bridge (D_BRIDGE_POSTED_WRITE_EN aware)
module tb_d_mem_byte_bridge;

  localparam int TO = 4;
`ifdef D_BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } beat_t;

  logic        clk;
  logic        a_rst;
  logic        d_mem_assert, d_mem_cmd, d_mem_be0, d_mem_be1;
  logic [15:0] d_mem_addr, d_mem_data_out, d_mem_data_in;
  logic        d_mem_rdy, d_mem_err;
  logic        ext_req, ext_we, ext_ack;
  logic [15:0] ext_addr;
  logic [7:0]  ext_wdata, ext_rdata;

  int          vectors = 0;
  int          miscompares = 0;
  int          wait_cycles = 0;
  bit          no_ack = 1'b0;
  int          wcnt = 0;
  logic [7:0]  mem [0:1023];
  beat_t       beat_q[$];
  beat_t       mon_exp;

  d_mem_byte_bridge #(.TIMEOUT(TO), .BUS_ERR_DATA(16'hFFFF)) dut (
    .clk            (clk),
    .a_rst          (a_rst),
    .d_mem_assert   (d_mem_assert),
    .d_mem_cmd      (d_mem_cmd),
    .d_mem_be0      (d_mem_be0),
    .d_mem_be1      (d_mem_be1),
    .d_mem_addr     (d_mem_addr),
    .d_mem_data_out (d_mem_data_out),
    .d_mem_data_in  (d_mem_data_in),
    .d_mem_rdy      (d_mem_rdy),
    .d_mem_err      (d_mem_err),
    .ext_req        (ext_req),
    .ext_we         (ext_we),
    .ext_addr       (ext_addr),
    .ext_wdata      (ext_wdata),
    .ext_rdata      (ext_rdata),
    .ext_ack        (ext_ack)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Slave: ack after wait_cycles stalled cycles, data from the byte memory
  always @(negedge clk) begin
    if (ext_req && !no_ack && wcnt >= wait_cycles) begin
      ext_ack   = 1'b1;
      ext_rdata = mem[ext_addr[9:0]];
    end else begin
      ext_ack   = 1'b0;
      ext_rdata = 8'h00;
    end
  end

  always @(posedge clk) begin
    if (!a_rst) begin
      wcnt <= 0;
    end else if (ext_req && ext_ack) begin
      wcnt <= 0;
      if (ext_we) mem[ext_addr[9:0]] <= ext_wdata;
      vectors++;
      if (beat_q.size() == 0) begin
        miscompares++;
        $display("FAIL beat_unexpected got we=%0b addr=%h wdata=%h want no beat", ext_we, ext_addr, ext_wdata);
      end else begin
        mon_exp = beat_q.pop_front();
        if (ext_we !== mon_exp.we || ext_addr !== mon_exp.addr || (mon_exp.we && ext_wdata !== mon_exp.wdata)) begin
          miscompares++;
          $display("FAIL beat got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                   ext_we, ext_addr, ext_wdata, mon_exp.we, mon_exp.addr, mon_exp.wdata);
        end
      end
    end else if (ext_req) begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic do_req(input logic cmd, input logic be0, input logic be1, input logic [15:0] addr,
                        input logic [15:0] data, input int budget,
                        output int lat, output logic [15:0] din, output logic err);
    d_mem_assert = 1'b1; d_mem_cmd = cmd; d_mem_be0 = be0; d_mem_be1 = be1;
    d_mem_addr = addr; d_mem_data_out = data;
    lat = -1; din = 'x; err = 'x;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (d_mem_rdy === 1'b1) begin
        lat = k; din = d_mem_data_in; err = d_mem_err;
        break;
      end
    end
    d_mem_assert = 1'b0;
  endtask

  task automatic wait_quiet();
    @(negedge clk);
    for (int n = 0; n < 50 && ext_req; n++) @(negedge clk);
  endtask

  task automatic test_reset();
    a_rst = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({ext_req, ext_we, d_mem_rdy, d_mem_err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 0000", {ext_req, ext_we, d_mem_rdy, d_mem_err});
    end
    vectors++;
    if (ext_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_addr got %h want 0000", ext_addr); end
    vectors++;
    if (ext_wdata !== 8'h00) begin miscompares++; $display("FAIL reset_wdata got %h want 00", ext_wdata); end
    vectors++;
    if (d_mem_data_in !== 16'h0000) begin miscompares++; $display("FAIL reset_din got %h want 0000", d_mem_data_in); end
    a_rst = 1'b1;
  endtask

  task automatic test_word_read();
    int lat; logic [15:0] din; logic err;
    wait_quiet();
    beat_q.push_back('{1'b0, 16'h00A0, 8'h00});
    beat_q.push_back('{1'b0, 16'h00A1, 8'h00});
    do_req(1'b0, 1'b1, 1'b1, 16'h00A0, 16'h0000, 20, lat, din, err);
    vectors++;
    if (lat !== 3) begin miscompares++; $display("FAIL word_read_lat got %0d want 3", lat); end
    vectors++;
    if (din !== 16'h1234) begin miscompares++; $display("FAIL word_read_data got %h want 1234", din); end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL word_read_err got %b want 0", err); end
  endtask

  task automatic test_byte_write();
    int lat; logic [15:0] din; logic err;
    wait_quiet();
    beat_q.push_back('{1'b1, 16'h00A3, 8'h5A});
    do_req(1'b1, 1'b0, 1'b1, 16'h00A3, 16'h005A, 20, lat, din, err);
    vectors++;
    if (lat !== (POSTED ? 1 : 2)) begin miscompares++; $display("FAIL byte_write_lat got %0d want %0d", lat, POSTED ? 1 : 2); end
    vectors++;
    if (din !== 16'h1234) begin miscompares++; $display("FAIL write_keeps_din got %h want 1234", din); end
    wait_quiet();
    vectors++;
    if (mem[10'h0A3] !== 8'h5A) begin miscompares++; $display("FAIL byte_write_mem got %h want 5a", mem[10'h0A3]); end
    vectors++;
    if (mem[10'h0A2] !== 8'h77) begin miscompares++; $display("FAIL byte_write_neighbour got %h want 77", mem[10'h0A2]); end
  endtask

  task automatic test_wait_word_write();
    int lat; logic [15:0] din; logic err;
    wait_quiet();
    wait_cycles = 3;
    beat_q.push_back('{1'b1, 16'h0100, 8'hBE});
    beat_q.push_back('{1'b1, 16'h0101, 8'hEF});
    do_req(1'b1, 1'b1, 1'b1, 16'h0101, 16'hBEEF, 40, lat, din, err);
    vectors++;
    if (lat !== (POSTED ? 1 : 9)) begin miscompares++; $display("FAIL wait_write_lat got %0d want %0d", lat, POSTED ? 1 : 9); end
    wait_quiet();
    wait_cycles = 0;
    vectors++;
    if ({mem[10'h100], mem[10'h101]} !== 16'hBEEF) begin
      miscompares++; $display("FAIL wait_write_mem got %h want beef", {mem[10'h100], mem[10'h101]});
    end
  endtask

  task automatic test_byte_read();
    int lat; logic [15:0] din; logic err;
    wait_quiet();
    beat_q.push_back('{1'b0, 16'h00A3, 8'h00});
    do_req(1'b0, 1'b0, 1'b1, 16'h00A3, 16'h0000, 20, lat, din, err);
    vectors++;
    if (lat !== 2) begin miscompares++; $display("FAIL byte_read_lat got %0d want 2", lat); end
    vectors++;
    if (din !== 16'h005A) begin miscompares++; $display("FAIL byte_read_odd got %h want 005a", din); end
    wait_quiet();
    beat_q.push_back('{1'b0, 16'h00A0, 8'h00});
    do_req(1'b0, 1'b1, 1'b0, 16'h00A0, 16'h0000, 20, lat, din, err);
    vectors++;
    if (din !== 16'h0012) begin miscompares++; $display("FAIL byte_read_even got %h want 0012", din); end
  endtask

  task automatic test_timeout();
    int lat, req_cycles; logic [15:0] din; logic err;
    wait_quiet();
    no_ack = 1'b1;
    d_mem_assert = 1'b1; d_mem_cmd = 1'b0; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_addr = 16'h0200; d_mem_data_out = 16'h0000;
    lat = -1; req_cycles = 0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ext_req) req_cycles++;
      if (d_mem_rdy === 1'b1) begin lat = k; err = d_mem_err; break; end
    end
    d_mem_assert = 1'b0;
    vectors++;
    if (req_cycles !== TO) begin miscompares++; $display("FAIL timeout_req_cycles got %0d want %0d", req_cycles, TO); end
    vectors++;
    if (lat !== TO + 1) begin miscompares++; $display("FAIL timeout_lat got %0d want %0d", lat, TO + 1); end
    vectors++;
    if (err !== 1'b1) begin miscompares++; $display("FAIL timeout_err got %b want 1", err); end
    vectors++;
    if (d_mem_data_in !== 16'hFFFF) begin miscompares++; $display("FAIL timeout_data got %h want ffff", d_mem_data_in); end
    wait_quiet();
    do_req(1'b0, 1'b0, 1'b1, 16'h0201, 16'h0000, 20, lat, din, err);
    vectors++;
    if ({err, din} !== {1'b1, 16'h00FF}) begin
      miscompares++; $display("FAIL timeout_byte got err=%b data=%h want err=1 data=00ff", err, din);
    end
    no_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] din; logic err;
    wait_quiet();
    wait_cycles = 2;
    beat_q.push_back('{1'b1, 16'h0300, 8'h11});
    d_mem_assert = 1'b1; d_mem_cmd = 1'b1; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_addr = 16'h0300; d_mem_data_out = 16'h1122;
    repeat (4) @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ext_req, d_mem_rdy, d_mem_err} !== 3'b000) begin
      miscompares++; $display("FAIL midreset_ctrl got %b want 000", {ext_req, d_mem_rdy, d_mem_err});
    end
    vectors++;
    if ({mem[10'h300], mem[10'h301]} !== 16'h1166) begin
      miscompares++; $display("FAIL midreset_mem got %h want 1166", {mem[10'h300], mem[10'h301]});
    end
    d_mem_assert = 1'b0;
    a_rst = 1'b1;
    wait_cycles = 0;
    beat_q.push_back('{1'b0, 16'h00A0, 8'h00});
    beat_q.push_back('{1'b0, 16'h00A1, 8'h00});
    do_req(1'b0, 1'b1, 1'b1, 16'h00A0, 16'h0000, 20, lat, din, err);
    vectors++;
    if ({lat, din, err} !== {32'd3, 16'h1234, 1'b0}) begin
      miscompares++; $display("FAIL midreset_recover got lat=%0d data=%h err=%b want lat=3 data=1234 err=0", lat, din, err);
    end
  endtask

`ifdef D_BRIDGE_POSTED_WRITE_EN
  task automatic test_posted();
    int lat; logic [15:0] din; logic err;
    wait_quiet();
    beat_q.push_back('{1'b1, 16'h0400, 8'hCA});
    beat_q.push_back('{1'b1, 16'h0401, 8'hFE});
    beat_q.push_back('{1'b0, 16'h0400, 8'h00});
    beat_q.push_back('{1'b0, 16'h0401, 8'h00});
    do_req(1'b1, 1'b1, 1'b1, 16'h0400, 16'hCAFE, 20, lat, din, err);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL posted_write_lat got %0d want 1", lat); end
    do_req(1'b0, 1'b1, 1'b1, 16'h0400, 16'h0000, 20, lat, din, err);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL posted_read_lat got %0d want 5", lat); end
    vectors++;
    if ({din, err} !== {16'hCAFE, 1'b0}) begin
      miscompares++; $display("FAIL posted_read_data got %h err=%b want cafe err=0", din, err);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b0; d_mem_assert = 1'b0; d_mem_cmd = 1'b0; d_mem_be0 = 1'b0; d_mem_be1 = 1'b0;
    d_mem_addr = 16'h0000; d_mem_data_out = 16'h0000;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h0A0] = 8'h12; mem[10'h0A1] = 8'h34; mem[10'h0A2] = 8'h77;
    mem[10'h301] = 8'h66;
    test_reset();
    test_word_read();
    test_byte_write();
    test_wait_word_write();
    test_byte_read();
    test_timeout();
    test_reset_mid();
`ifdef D_BRIDGE_POSTED_WRITE_EN
    test_posted();
`endif
    wait_quiet();
    vectors++;
    if (beat_q.size() !== 0) begin miscompares++; $display("FAIL beats_outstanding got %0d want 0", beat_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
